// File: rtl/multiword_adder_pkg.sv
// Shared types and constants for the streaming multi-precision adder.
// Optional build macro used by multiword_adder: MULTIWORD_ADDER_CIN_EN.
package multiword_adder_pkg;

  localparam int MWA_DATA_WIDTH = 4;

  // ST_FIRST: next accepted word starts a new number; ST_CONT: carry chain active.
  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_CONT  = 1'b1
  } state_t;

endpackage

// File: rtl/multiword_adder_ripple_adder_comb.sv
// Combinational ripple-carry word adder: {o_co, o_s} = i_a + i_b + i_ci.
// Purely combinational; the wrapper supplies carry-in and registers the result.
module ripple_adder_comb #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_ci,
  output logic [DATA_WIDTH-1:0] o_s,
  output logic                  o_co
);

  logic [DATA_WIDTH:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_fa
    logic w_p;
    assign w_p        = i_a[g] ^ i_b[g];
    assign o_s[g]     = w_p ^ w_c[g];
    assign w_c[g+1]   = (i_a[g] & i_b[g]) | (w_c[g] & w_p);
  end

  assign o_co = w_c[DATA_WIDTH];

endmodule

// File: rtl/multiword_adder.sv
// Streaming multi-precision adder: words arrive LS-first, carry is chained through r_c.
// Build option MULTIWORD_ADDER_CIN_EN adds in_ci, the carry-in for the first word of a number.
//
// Handshake: a word moves on a stream only in a cycle where valid & ready are both 1
// at the rising edge; valid never depends on ready, and fields hold while valid & !ready.
module multiword_adder
  import multiword_adder_pkg::*;
#(
  parameter int DATA_WIDTH = MWA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
`ifdef MULTIWORD_ADDER_CIN_EN
  input  logic                  in_ci,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_s,
  output logic                  out_co,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output state_t                out_dbg_state
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_c;
  logic                  w_c_nxt;
  logic                  w_cin;
  logic                  w_cin_first;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_co;

  logic [DATA_WIDTH-1:0] r_out_s;
  logic                  r_out_co;
  logic                  r_out_last;
  logic                  r_out_valid;

`ifdef MULTIWORD_ADDER_CIN_EN
  assign w_cin_first = in_ci;
`else
  assign w_cin_first = 1'b0;
`endif

  // Ready depends only on the output register and out_ready, never on in_valid.
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  ripple_adder_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_adder (
    .i_a  (in_a),
    .i_b  (in_b),
    .i_ci (w_cin),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FIRST;
      r_c     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_cin       = 1'b0;
    case (r_state)
      ST_FIRST: w_cin = w_cin_first;
      ST_CONT:  w_cin = r_c;
      default:  w_cin = 1'b0;
    endcase
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt = ST_FIRST;
        w_c_nxt     = 1'b0;
      end else begin
        w_state_nxt = ST_CONT;
        w_c_nxt     = w_co;
      end
    end
  end

  // One-entry output register; a push in the same cycle as a pop simply reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_s     <= '0;
      r_out_co    <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_s     <= w_sum;
      r_out_co    <= w_co;
      r_out_last  <= in_last;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_s         = r_out_s;
  assign out_co        = r_out_co;
  assign out_last      = r_out_last;
  assign out_valid     = r_out_valid;
  assign out_dbg_state = r_state;

endmodule

// File: doc/multiword_adder.md
# multiword_adder

Streaming multi-precision adder wrapped around a combinational ripple-carry word adder. Accepts operand words least-significant first on a valid/ready stream, chains each word's carry-out into the next word's carry-in through a register, and emits registered sum words on an output stream. It sits directly upstream of the word adder, sequencing its carry input, and directly downstream of it, capturing its sum and carry-out.

## Interface
- DATA_WIDTH, 4, operand/sum word width in bits (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_a  in  DATA_WIDTH  operand A word
- in_b  in  DATA_WIDTH  operand B word
- in_last  in  1  marks most-significant word of a number
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted when in_valid & in_ready
- out_s  out  DATA_WIDTH  sum word
- out_co  out  1  carry-out of this word; meaningful as final carry when out_last=1
- out_last  out  1  copy of in_last for this word
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts when out_valid & out_ready

## Operation
- Word state: FIRST (next accepted word starts a number) and CONT (carry chain active). Reset → FIRST.
- Carry register c: reset 0. Word adder carry-in = c in CONT; in FIRST = 0 (or in_ci, see Configuration).
- On accept: out_s ← (in_a + in_b + cin) mod 2^DATA_WIDTH; out_co ← carry-out; out_last ← in_last; out_valid ← 1.
- On accept with in_last=0: c ← carry-out, state → CONT. With in_last=1: c ← 0, state → FIRST.
- One-entry output register: in_ready = !out_valid | out_ready (combinational pass-through of out_ready allowed; no path from in_valid to in_ready).
- out_valid clears when out_ready & out_valid & !(accept same cycle).
- Simultaneous pop and push: register reloads, out_valid stays 1, no bubble.
- Output fields hold stable while out_valid & !out_ready.
- Single-word number (in_last=1 in FIRST): plain add with cin from FIRST rule.
- Reset mid-number: partial number discarded, state FIRST, c=0, out_valid=0.

## Timing
- Reset values: out_valid=0, out_s=0, out_co=0, out_last=0; in_ready=1 after reset.
- Latency: word accepted at edge N appears on outputs after edge N, i.e. valid in cycle N+1.
- Throughput: one word per cycle when out_ready held high.
- Carry path: register c → word adder → out register; one word-adder delay per cycle, no multi-cycle paths.

## Configuration
- MULTIWORD_ADDER_CIN_EN defined: extra port in_ci (in, 1), sampled only on a word accepted in state FIRST and used as its carry-in; ignored in CONT.
- Not defined: no in_ci port; first word of every number uses carry-in 0.

## Structure
- Package multiword_adder_pkg: DATA_WIDTH default constant, state enum {ST_FIRST, ST_CONT}.
- One sub-module: ripple_adder_comb (DATA_WIDTH-wide combinational a+b+ci → s, co), instantiated once; all sequencing in multiword_adder.

## Test plan
- Single word, DATA_WIDTH=4: a=0x9, b=0x8, last=1 → next cycle out_s=0x1, out_co=1, out_last=1, out_valid=1.
- Three-word chain: (a,b)=(0xF,0x1),(0xF,0x0),(0x2,0x3), last on third → out_s 0x0,0x0,0x6; out_co 1,1,0; i.e. 0x2FF+0x301=0x600.
- Back-pressure: hold out_ready=0 with a word stored → in_ready=0, outputs frozen 5 cycles; release → one word per cycle, no loss, no duplicate.
- Back-to-back numbers: (0xF,0x1,last) then (0x1,0x1,last) → second out_s=0x2 (carry not leaked across numbers).
- Async reset asserted between words 1 and 2 of a chain → outputs zero immediately; next word treated as FIRST with carry 0.
- With MULTIWORD_ADDER_CIN_EN: in_ci=1, a=0x7, b=0x8, last=0, then (0x0,0x0,last) with in_ci=1 → out_s 0x0 co=1, then out_s 0x1 (in_ci ignored in CONT).
